// File: rtl/div_subshift_if.sv
// Handshake/data bundle for the shift-subtract divider.
interface div_subshift_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic              sign;
  logic              done;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output en, sign, dividend, divisor,
    input  done, quotient, remainder
  );

  modport slave (
    input  en, sign, dividend, divisor,
    output done, quotient, remainder
  );
endinterface

// File: rtl/div_subshift.sv
// Restoring shift-subtract divider: one quotient bit per cycle, signed/unsigned,
// RISC-V divide-by-zero and overflow result conventions.
module div_subshift #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_subshift_if.slave  bus
);
  localparam int PCW = $clog2(DATA_W + 2) + 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(DATA_W);
  localparam logic [PCW-1:0] PC_FIX  = PCW'(DATA_W + 1);

  logic [PCW-1:0]    pc_q, pc_d;
  logic              sign_reg_q, sign_reg_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              div_zero_q, div_zero_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [DATA_W-1:0] dvnd_raw_q, dvnd_raw_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] trial;
  logic [DATA_W-1:0] dvnd_abs;
  logic [DATA_W-1:0] dvsr_abs;
  logic [DATA_W-1:0] r_mag;

  always_comb begin
    pc_d       = pc_q;
    sign_reg_d = sign_reg_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div_zero_d = div_zero_q;
    done_d     = done_q;
    dvsr_d     = dvsr_q;
    dvnd_raw_d = dvnd_raw_q;
    rem_d      = rem_q;
    quo_d      = quo_q;

    // Remainder stays below the divisor, so bit DATA_W+1 of the trial is its sign.
    shifted  = {rem_q, quo_q[DATA_W-1]};
    trial    = shifted - {2'b00, dvsr_q};
    dvnd_abs = (bus.sign && bus.dividend[DATA_W-1]) ? -bus.dividend : bus.dividend;
    dvsr_abs = (bus.sign && bus.divisor[DATA_W-1])  ? -bus.divisor  : bus.divisor;
    r_mag    = rem_q[DATA_W-1:0];

    if (!bus.en) begin
      pc_d       = '0;
      sign_reg_d = 1'b0;
      neg_q_d    = 1'b0;
      neg_r_d    = 1'b0;
      div_zero_d = 1'b0;
      done_d     = 1'b0;
      dvsr_d     = '0;
      dvnd_raw_d = '0;
      rem_d      = '0;
      quo_d      = '0;
    end else if (pc_q == '0) begin
      pc_d       = pc_q + 1'b1;
      sign_reg_d = bus.sign;
      neg_q_d    = bus.sign & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
      neg_r_d    = bus.sign & bus.dividend[DATA_W-1];
      div_zero_d = (bus.divisor == '0);
      dvsr_d     = dvsr_abs;
      dvnd_raw_d = bus.dividend;
      rem_d      = '0;
      quo_d      = dvnd_abs;
    end else if (pc_q <= PC_LAST) begin
      pc_d = pc_q + 1'b1;
      if (!trial[DATA_W+1]) begin
        rem_d = trial[DATA_W:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DATA_W:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end else if (pc_q == PC_FIX) begin
      pc_d   = pc_q + 1'b1;
      done_d = 1'b1;
      if (div_zero_q) begin
        quo_d = '1;
        rem_d = {1'b0, dvnd_raw_q};
      end else begin
        quo_d = (sign_reg_q && neg_q_q) ? -quo_q : quo_q;
        rem_d = {1'b0, (neg_r_q ? -r_mag : r_mag)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      sign_reg_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      dvsr_q     <= '0;
      dvnd_raw_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      sign_reg_q <= sign_reg_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      dvsr_q     <= dvsr_d;
      dvnd_raw_q <= dvnd_raw_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q[DATA_W-1:0];
endmodule

// File: tb/tb_div_subshift.sv
// Randomised and directed bench for div_subshift at DATA_W=32 and DATA_W=8,
// checked against an arithmetic reference model.
module tb_div_subshift;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  div_subshift_if #(.DATA_W(32)) bus32 ();
  div_subshift_if #(.DATA_W(8))  bus8 ();

  div_subshift #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  div_subshift #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V style division at width w using native 64-bit arithmetic.
  function automatic void ref_div(input int unsigned w, input logic s,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [63:0] mask;
    logic [63:0] a, b;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (s) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = (a / b) & mask;
      r = (a % b) & mask;
    end
  endfunction

  task automatic run32(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [63:0] eq, er;
    int n;
    ref_div(32, s, {32'd0, a}, {32'd0, b}, eq, er);
    bus32.en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_clr"}, {63'd0, bus32.done}, 64'd0);
    bus32.sign = s; bus32.dividend = a; bus32.divisor = b; bus32.en = 1'b1;
    @(posedge clk); #1;
    n = 1;
    bus32.dividend = $urandom; bus32.divisor = $urandom; bus32.sign = 1'($urandom);
    while (!bus32.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_q"}, {32'd0, bus32.quotient}, eq);
    chk({tag, "_r"}, {32'd0, bus32.remainder}, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_done"}, {63'd0, bus32.done}, 64'd1);
      chk({tag, "_hold_q"}, {32'd0, bus32.quotient}, eq);
      chk({tag, "_hold_r"}, {32'd0, bus32.remainder}, er);
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [63:0] eq, er;
    int n;
    ref_div(8, s, {56'd0, a}, {56'd0, b}, eq, er);
    bus8.en = 1'b0;
    @(posedge clk); #1;
    bus8.sign = s; bus8.dividend = a; bus8.divisor = b; bus8.en = 1'b1;
    @(posedge clk); #1;
    n = 1;
    bus8.dividend = 8'($urandom); bus8.divisor = 8'($urandom);
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("r8_lat", 64'(n), 64'd10);
    chk("r8_q", {56'd0, bus8.quotient}, eq);
    chk("r8_r", {56'd0, bus8.remainder}, er);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 9))
      0: return 8'd0;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'd1;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    bus32.en = 1'b0; bus32.sign = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.en  = 1'b0; bus8.sign  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    bus32.en = 1'b1; bus8.en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {63'd0, bus32.done}, 64'd0);
    chk("rst_q", {32'd0, bus32.quotient}, 64'd0);
    chk("rst_r", {32'd0, bus32.remainder}, 64'd0);
    chk("rst_done8", {63'd0, bus8.done}, 64'd0);
    rst = 1'b0;
    bus32.en = 1'b0; bus8.en = 1'b0;

    run32("u100_7", 1'b0, 32'd100, 32'd7, 10);
    run32("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);
    run32("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    run32("u_dz", 1'b0, 32'h1234, 32'd0, 2);
    run32("s_dz", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2);
    run32("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run32("u_3_max", 1'b0, 32'd3, 32'hFFFF_FFFF, 0);
    chk("lit_u100_q", 64'(dut32.bus.quotient), 64'd0);
    checks--;

    // Abort mid-operation by dropping en.
    bus32.en = 1'b0;
    @(posedge clk); #1;
    bus32.sign = 1'b0; bus32.dividend = 32'd100; bus32.divisor = 32'd7; bus32.en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus32.en = 1'b0;
    @(posedge clk); #1;
    chk("abort_done", {63'd0, bus32.done}, 64'd0);
    chk("abort_q", {32'd0, bus32.quotient}, 64'd0);
    chk("abort_r", {32'd0, bus32.remainder}, 64'd0);
    run32("restart", 1'b0, 32'd50, 32'd5, 0);

    // Reset pulse mid-operation with en held high.
    bus32.en = 1'b0;
    @(posedge clk); #1;
    bus32.sign = 1'b0; bus32.dividend = 32'd1000; bus32.divisor = 32'd3; bus32.en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_done", {63'd0, bus32.done}, 64'd0);
    chk("rstmid_q", {32'd0, bus32.quotient}, 64'd0);
    chk("rstmid_r", {32'd0, bus32.remainder}, 64'd0);
    rst = 1'b0;
    n = 0;
    while (!bus32.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_lat", 64'(n), 64'd34);
    chk("rstmid_q2", {32'd0, bus32.quotient}, 64'd333);
    chk("rstmid_r2", {32'd0, bus32.remainder}, 64'd1);

    for (int i = 0; i < 500; i++)
      run32("rnd32", 1'($urandom), pick32(), pick32(), 0);
    for (int i = 0; i < 1500; i++)
      run8(1'($urandom), pick8(), pick8());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
